serial_byte_loader: RTL and testbench

- Serial-to-parallel front end that collects bits from a one-bit serial source and assembles them into a WIDTH-bit word.
- Drives the data input of the eight_bit_register stage directly downstream. That register loads on every clock, so this block holds its parallel output stable between completed words.
- Uses a valid/ready handshake so a controller can tell when a fresh word is on the bus.

---
 rtl/serial_byte_loader.sv | 159 +++++++++++++++
 tb/tb_serial_byte_loader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel word loader with valid/ready output handshake.
// Optional even-parity trailer bit enabled by SERIAL_BYTE_LOADER_PARITY_CHECK_EN.
module serial_byte_loader #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             ser_in_i,
  input  logic             ser_valid_i,
  output logic [WIDTH-1:0] byte_out_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
  typedef enum logic [1:0] {StIdle, StShift, StParity, StHold} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] byte_out_q, byte_out_d;
  logic             byte_valid_q, byte_valid_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shift_in;

`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
`endif

  // After WIDTH shifts the first bit sits at bit 0 (LSB-first) or bit WIDTH-1 (MSB-first).
  always_comb begin
    if (MSB_FIRST) begin
      shift_in = {shift_q[WIDTH-2:0], ser_in_i};
    end else begin
      shift_in = {ser_in_i, shift_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = byte_valid_q;
    overrun_d    = overrun_q;
`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end
      end

      StShift: begin
        if (start_i) begin
          cnt_d   = '0;
          shift_d = '0;
        end else if (ser_valid_i) begin
          shift_d = shift_in;
          if (cnt_q == LastCnt) begin
            cnt_d = '0;
`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
            state_d = StParity;
`else
            byte_out_d   = shift_in;
            byte_valid_d = 1'b1;
            state_d      = StHold;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
      StParity: begin
        if (start_i) begin
          state_d = StShift;
          cnt_d   = '0;
          shift_d = '0;
        end else if (ser_valid_i) begin
          byte_out_d   = shift_q;
          byte_valid_d = 1'b1;
          parity_err_d = (^shift_q) ^ ser_in_i;
          state_d      = StHold;
        end
      end
`endif

      StHold: begin
        if (byte_ready_i) begin
          byte_valid_d = 1'b0;
          cnt_d        = '0;
          shift_d      = '0;
          state_d      = start_i ? StShift : StIdle;
        end else if (start_i) begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      shift_q      <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_o = parity_err_q;
  assign busy_o       = (state_q == StShift) || (state_q == StParity);
`else
  assign parity_err_o = 1'b0;
  assign busy_o       = (state_q == StShift);
`endif

  assign byte_out_o   = byte_out_q;
  assign byte_valid_o = byte_valid_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Scoreboard bench for serial_byte_loader (WIDTH=8, LSB first).
module tb_serial_byte_loader;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       ser_in_i = 1'b0;
  logic       ser_valid_i = 1'b0;
  logic [7:0] byte_out_o;
  logic       byte_valid_o;
  logic       byte_ready_i = 1'b0;
  logic       busy_o;
  logic       overrun_o;
  logic       parity_err_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  exp_q[$];
  logic        valid_prev = 1'b0;

  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .ser_in_i     (ser_in_i),
    .ser_valid_i  (ser_valid_i),
    .byte_out_o   (byte_out_o),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o),
    .parity_err_o (parity_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every rising byte_valid must match the oldest word pushed by the stimulus.
  always @(negedge clk_i) begin
    if (byte_valid_o && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_word", {24'h0, byte_out_o}, 32'hFFFF_FFFF);
      end else begin
        check_eq("sb_word", {24'h0, byte_out_o}, {24'h0, exp_q.pop_front()});
      end
    end
    valid_prev = byte_valid_o;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    ser_valid_i = 1'b1;
    ser_in_i    = b;
    step();
    ser_valid_i = 1'b0;
    ser_in_i    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic par);
    exp_q.push_back(w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
    send_bit(par);
`else
    if (par) begin end
`endif
  endtask

  task automatic handshake();
    byte_ready_i = 1'b1;
    step();
    byte_ready_i = 1'b0;
  endtask

  initial begin
    // Reset then idle
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step();
    check_eq("rst_byte_out", {24'h0, byte_out_o}, 32'h00);
    check_eq("rst_valid", {31'h0, byte_valid_o}, 32'h0);
    check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
    check_eq("rst_overrun", {31'h0, overrun_o}, 32'h0);
    check_eq("rst_parity_err", {31'h0, parity_err_o}, 32'h0);

    // ser_valid in IDLE is ignored
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check_eq("idle_busy", {31'h0, busy_o}, 32'h0);
    check_eq("idle_valid", {31'h0, byte_valid_o}, 32'h0);

    // LSB-first load of A5, one-edge latency
    pulse_start();
    check_eq("shift_busy", {31'h0, busy_o}, 32'h1);
    send_word(8'hA5, 1'b0);
    check_eq("a5_valid", {31'h0, byte_valid_o}, 32'h1);
    check_eq("a5_busy", {31'h0, busy_o}, 32'h0);
    check_eq("a5_parity_err", {31'h0, parity_err_o}, 32'h0);
    handshake();
    check_eq("a5_valid_after_rdy", {31'h0, byte_valid_o}, 32'h0);
    check_eq("a5_byte_kept", {24'h0, byte_out_o}, 32'hA5);

    // Stall and abort; restart cycle carries ser_valid=1 which must be ignored
    pulse_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    repeat (2) step();
    check_eq("stall_busy", {31'h0, busy_o}, 32'h1);
    check_eq("stall_valid", {31'h0, byte_valid_o}, 32'h0);
    start_i     = 1'b1;
    ser_valid_i = 1'b1;
    ser_in_i    = 1'b1;
    step();
    start_i     = 1'b0;
    ser_valid_i = 1'b0;
    ser_in_i    = 1'b0;
    check_eq("abort_byte_untouched", {24'h0, byte_out_o}, 32'hA5);
    send_word(8'h3C, 1'b0);
    check_eq("3c_byte", {24'h0, byte_out_o}, 32'h3C);
    handshake();

    // Overrun then back-to-back
    pulse_start();
    send_word(8'h5A, 1'b0);
    pulse_start();
    check_eq("ovr_flag", {31'h0, overrun_o}, 32'h1);
    check_eq("ovr_valid", {31'h0, byte_valid_o}, 32'h1);
    check_eq("ovr_byte", {24'h0, byte_out_o}, 32'h5A);
    check_eq("ovr_busy", {31'h0, busy_o}, 32'h0);
    start_i      = 1'b1;
    byte_ready_i = 1'b1;
    step();
    start_i      = 1'b0;
    byte_ready_i = 1'b0;
    check_eq("b2b_busy", {31'h0, busy_o}, 32'h1);
    check_eq("b2b_valid", {31'h0, byte_valid_o}, 32'h0);
    send_word(8'hFF, 1'b0);
    check_eq("ff_byte", {24'h0, byte_out_o}, 32'hFF);
    check_eq("ff_overrun_sticky", {31'h0, overrun_o}, 32'h1);
    handshake();

    // Mid-word reset
    pulse_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_ni = 1'b0;
    #1;
    check_eq("mrst_byte_out", {24'h0, byte_out_o}, 32'h00);
    check_eq("mrst_valid", {31'h0, byte_valid_o}, 32'h0);
    check_eq("mrst_busy", {31'h0, busy_o}, 32'h0);
    check_eq("mrst_overrun", {31'h0, overrun_o}, 32'h0);
    step();
    rst_ni = 1'b1;
    step();
    pulse_start();
    send_word(8'h01, 1'b1);
    check_eq("01_byte", {24'h0, byte_out_o}, 32'h01);
    handshake();

`ifdef SERIAL_BYTE_LOADER_PARITY_CHECK_EN
    pulse_start();
    send_word(8'h0F, 1'b0);
    check_eq("par_0f_err", {31'h0, parity_err_o}, 32'h0);
    handshake();
    pulse_start();
    send_word(8'h07, 1'b0);
    check_eq("par_07_err", {31'h0, parity_err_o}, 32'h1);
    check_eq("par_07_byte", {24'h0, byte_out_o}, 32'h07);
    handshake();
`endif

    step();
    check_eq("sb_drained", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
